// File: rtl/latch_write_ctrl.sv
// Writer side for a bank of level-sensitive D latches.
// A write word is accepted over a valid/ready handshake. The data bus is then
// held stable for SETUP_CYC cycles before the latch enable opens, through
// OPEN_CYC enable-high cycles, and for HOLD_CYC cycles after the enable closes.
// A shadow copy of the latched value is kept for readback.
//
// Handshake: a write is accepted on any rising edge where wr_valid=1 and
// wr_ready=1. wr_ready is high exactly while the FSM is IDLE. wr_data is
// sampled only on that edge. wr_valid and wr_data are ignored at all other
// times, and the requester may change them freely.
module latch_write_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             en_out,
  output logic [WIDTH-1:0] q_shadow,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Reload values for the phase counter: a phase of N cycles counts N-1 .. 0.
  localparam logic [7:0] SETUP_INIT = 8'(SETUP_CYC - 1);
  localparam logic [7:0] OPEN_INIT  = 8'(OPEN_CYC - 1);
  localparam logic [7:0] HOLD_INIT  = 8'(HOLD_CYC - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   d_out_q, d_out_d;
  logic               en_q, en_d;
  logic [WIDTH-1:0]   q_shadow_q, q_shadow_d;
  logic               done_q, done_d;
  logic               wr_ready_q, wr_ready_d;

  // Next-state and registered-output logic for the write sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_out_d    = d_out_q;
    en_d       = en_q;
    q_shadow_d = q_shadow_q;
    done_d     = 1'b0;
    wr_ready_d = wr_ready_q;
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          // d_out only ever changes here, so it is stable for the whole window.
          d_out_d    = wr_data;
          wr_ready_d = 1'b0;
          cnt_d      = SETUP_INIT;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          en_d    = 1'b1;
          cnt_d   = OPEN_INIT;
          state_d = OPEN;
        end
      end
      OPEN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // The latch captures d_out as enable closes; mirror that here.
          en_d       = 1'b0;
          q_shadow_d = d_out_q;
          cnt_d      = HOLD_INIT;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          wr_ready_d = 1'b1;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        // Unreachable encoding: recover to a safe, closed-latch idle.
        en_d       = 1'b0;
        wr_ready_d = 1'b1;
        cnt_d      = 8'd0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers; reset closes the latch enable immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      d_out_q    <= '0;
      en_q       <= 1'b0;
      q_shadow_q <= '0;
      done_q     <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_out_q    <= d_out_d;
      en_q       <= en_d;
      q_shadow_q <= q_shadow_d;
      done_q     <= done_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign d_out     = d_out_q;
  assign en_out    = en_q;
  assign q_shadow  = q_shadow_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Bench for latch_write_ctrl: one instance with default timing and one with
// SETUP=3/OPEN=1/HOLD=2, both checked every cycle against a timeline model
// that derives every output from the cycle distance to the last accept.
module tb_latch_write_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT instances ----------------
  logic       wv [2];
  logic [7:0] wd [2];
  logic       rdy [2];
  logic [7:0] dq [2];
  logic       en [2];
  logic [7:0] sh [2];
  logic       dn [2];
  logic [1:0] st [2];

  latch_write_ctrl #(.WIDTH(8), .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)) u_dut (
    .clk(clk), .rst(rst), .wr_valid(wv[0]), .wr_data(wd[0]),
    .wr_ready(rdy[0]), .d_out(dq[0]), .en_out(en[0]), .q_shadow(sh[0]),
    .done(dn[0]), .state_dbg(st[0])
  );

  latch_write_ctrl #(.WIDTH(8), .SETUP_CYC(3), .OPEN_CYC(1), .HOLD_CYC(2)) u_dut_p (
    .clk(clk), .rst(rst), .wr_valid(wv[1]), .wr_data(wd[1]),
    .wr_ready(rdy[1]), .d_out(dq[1]), .en_out(en[1]), .q_shadow(sh[1]),
    .done(dn[1]), .state_dbg(st[1])
  );

  // ---------------- reference model ----------------
  int p_s [2] = '{1, 3};
  int p_o [2] = '{2, 1};
  int p_h [2] = '{1, 2};

  int         cyc;
  bit         m_has [2];
  int         m_t0 [2];
  logic [7:0] m_word [2];
  logic [7:0] m_shadow [2];
  logic [7:0] m_dlast [2];
  logic [7:0] exp_q [$];   // words expected to reach q_shadow of instance 0

  int n_checks = 0;
  int n_errors = 0;

  function automatic bit m_ready(int i);
    return !m_has[i] || (cyc - m_t0[i] >= p_s[i] + p_o[i] + p_h[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_has[i]    = 1'b0;
      m_t0[i]     = 0;
      m_word[i]   = 8'h00;
      m_shadow[i] = 8'h00;
      m_dlast[i]  = 8'h00;
    end
    exp_q.delete();
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    bit rp [2];
    for (int i = 0; i < 2; i++) rp[i] = m_ready(i);
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (rp[i] && wv[i]) begin
        m_has[i]   = 1'b1;
        m_t0[i]    = cyc;
        m_word[i]  = wd[i];
        m_dlast[i] = wd[i];
        if (i == 0) exp_q.push_back(wd[i]);
      end
      if (m_has[i] && (cyc - m_t0[i] == p_s[i] + p_o[i])) begin
        m_shadow[i] = m_word[i];
        if (i == 0 && exp_q.size() > 0) begin
          check_val("shadow_order0", {24'd0, m_word[i]}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs();
    int  rel;
    logic e_en, e_dn, e_rdy;
    for (int i = 0; i < 2; i++) begin
      rel   = cyc - m_t0[i];
      e_en  = m_has[i] && rel >= p_s[i] && rel < p_s[i] + p_o[i];
      e_dn  = m_has[i] && rel == p_s[i] + p_o[i] + p_h[i];
      e_rdy = m_ready(i);
      check_val($sformatf("en%0d", i),     {31'd0, en[i]},  {31'd0, e_en});
      check_val($sformatf("done%0d", i),   {31'd0, dn[i]},  {31'd0, e_dn});
      check_val($sformatf("ready%0d", i),  {31'd0, rdy[i]}, {31'd0, e_rdy});
      check_val($sformatf("d_out%0d", i),  {24'd0, dq[i]},  {24'd0, m_dlast[i]});
      check_val($sformatf("shadow%0d", i), {24'd0, sh[i]},  {24'd0, m_shadow[i]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input int i, input logic v, input logic [7:0] d);
    wv[i] = v;
    wd[i] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    cyc = 0;
    model_reset();
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // Reset then idle.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // Single write on both instances, then churn wr_data while busy.
    drive(0, 1'b1, 8'hA5);
    drive(1, 1'b1, 8'h3C);
    step();
    check_val("accept_d0", {24'd0, dq[0]}, 32'h0000_00A5);
    check_val("accept_d1", {24'd0, dq[1]}, 32'h0000_003C);
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b0, 8'($urandom_range(0, 255)));
      drive(1, 1'b0, 8'($urandom_range(0, 255)));
      step();
    end
    check_val("stable_d0", {24'd0, dq[0]}, 32'h0000_00A5);
    check_val("shadow_a5", {24'd0, sh[0]}, 32'h0000_00A5);
    check_val("shadow_3c", {24'd0, sh[1]}, 32'h0000_003C);

    // Back-to-back with wr_valid held high.
    drive(0, 1'b1, 8'h11);
    step();
    drive(0, 1'b1, 8'h22);
    repeat (8) step();
    drive(0, 1'b0, 8'h00);
    repeat (4) step();
    check_val("b2b_shadow", {24'd0, sh[0]}, 32'h0000_0022);

    // Reset while the enable is open.
    drive(0, 1'b1, 8'h55);
    step();
    drive(0, 1'b0, 8'h00);
    waited = 0;
    while (en[0] !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    check_val("en_open_timeout", {31'd0, en[0]}, 32'd1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_val("async_en", {31'd0, en[0]}, 32'd0);
    check_val("async_shadow", {24'd0, sh[0]}, 32'd0);
    check_val("async_ready", {31'd0, rdy[0]}, 32'd1);
    check_val("async_d", {24'd0, dq[0]}, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    drive(0, 1'b1, 8'h7E);
    step();
    drive(0, 1'b0, 8'h00);
    repeat (6) step();
    check_val("post_rst_shadow", {24'd0, sh[0]}, 32'h0000_007E);

    // Randomized traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        drive(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      step();
    end
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (10) step();

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
